// File: rtl/uart_rx.sv
// UART receive engine: oversampled start/data/stop deserialiser with a one-entry holding register.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              pclk,
   input  logic              prst_n,
   input  logic              apb_en,
   input  logic              apb_bsel,
   input  logic              brg_rx_shift,
   input  logic              rxd,
   input  logic              rx_ready,
   input  logic              ovr_clr,
`ifdef UART_RX_PARITY_EN
   input  logic              apb_pen,
   input  logic              apb_eps,
`endif
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_ferr,
   output logic              rx_ovr,
   output logic              rx_busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic              rx_perr
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } state_t;

   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   state_t                  state;
   logic [3:0]              tick_cnt;
   logic [2:0]              bit_cnt;
   logic [DATA_W-1:0]       shift_reg;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    rxd_s;
   logic [3:0]              half_cnt;
   logic [3:0]              last_cnt;
   logic                    bit_end;
   logic                    load_evt;
   logic                    overrun;
`ifdef UART_RX_PARITY_EN
   logic                    par_q;
   logic                    perr_next;
`endif

   // The line idles high, so the synchroniser resets to 1 to avoid a false start bit.
   always_ff @(posedge pclk) begin
      if (!prst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      end
   end

   assign rxd_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      half_cnt = apb_bsel ? 4'd3 : 4'd7;
      last_cnt = apb_bsel ? 4'd7 : 4'd15;
   end

   // ">=" rather than "==" keeps a bsel change mid-frame from wrapping the counter a full turn.
   assign bit_end  = (tick_cnt >= last_cnt);
   assign load_evt = apb_en && brg_rx_shift && (state == ST_STOP) && bit_end;
   assign overrun  = load_evt && rx_valid && !rx_ready;
   assign rx_busy  = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
   assign perr_next = apb_pen && (par_q ^ (^shift_reg) ^ ~apb_eps);
`endif

   always_ff @(posedge pclk) begin
      if (!prst_n || !apb_en) begin
         state     <= ST_IDLE;
         tick_cnt  <= 4'd0;
         bit_cnt   <= 3'd0;
         shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else if (brg_rx_shift) begin
         case (state)
            ST_IDLE: begin
               if (!rxd_s) begin
                  state    <= ST_START;
                  tick_cnt <= 4'd0;
               end
            end
            ST_START: begin
               if (tick_cnt >= half_cnt) begin
                  tick_cnt <= 4'd0;
                  bit_cnt  <= 3'd0;
                  state    <= rxd_s ? ST_IDLE : ST_DATA;
               end else begin
                  tick_cnt <= tick_cnt + 4'd1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  tick_cnt  <= 4'd0;
                  shift_reg <= {rxd_s, shift_reg[DATA_W-1:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state <= apb_pen ? ST_PARITY : ST_STOP;
`else
                     state <= ST_STOP;
`endif
                  end
               end else begin
                  tick_cnt <= tick_cnt + 4'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  tick_cnt <= 4'd0;
                  par_q    <= rxd_s;
                  state    <= ST_STOP;
               end else begin
                  tick_cnt <= tick_cnt + 4'd1;
               end
            end
`endif
            ST_STOP: begin
               if (bit_end) begin
                  tick_cnt <= 4'd0;
                  state    <= rxd_s ? ST_IDLE : ST_BREAK;
               end else begin
                  tick_cnt <= tick_cnt + 4'd1;
               end
            end
            ST_BREAK: begin
               if (rxd_s) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               tick_cnt <= 4'd0;
            end
         endcase
      end
   end

   // A new frame only lands in the holding register if it is empty or being popped this cycle.
   always_ff @(posedge pclk) begin
      if (!prst_n) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         rx_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rx_perr  <= 1'b0;
`endif
      end else begin
         if (ovr_clr) begin
            rx_ovr <= 1'b0;
         end
         if (overrun) begin
            rx_ovr <= 1'b1;
         end else if (load_evt) begin
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
            rx_ferr  <= ~rxd_s;
`ifdef UART_RX_PARITY_EN
            rx_perr  <= perr_next;
`endif
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; frames are driven as serial waveforms with an oversample tick every 4 pclk.
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   logic       pclk;
   logic       prst_n;
   logic       apb_en;
   logic       apb_bsel;
   logic       brg_rx_shift;
   logic       rxd;
   logic       rx_ready;
   logic       ovr_clr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ferr;
   logic       rx_ovr;
   logic       rx_busy;
`ifdef UART_RX_PARITY_EN
   logic       apb_pen;
   logic       apb_eps;
   logic       rx_perr;
`endif

   int tests;
   int failed;
   int bit_clks;

   uart_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .pclk         (pclk),
      .prst_n       (prst_n),
      .apb_en       (apb_en),
      .apb_bsel     (apb_bsel),
      .brg_rx_shift (brg_rx_shift),
      .rxd          (rxd),
      .rx_ready     (rx_ready),
      .ovr_clr      (ovr_clr),
`ifdef UART_RX_PARITY_EN
      .apb_pen      (apb_pen),
      .apb_eps      (apb_eps),
      .rx_perr      (rx_perr),
`endif
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ferr      (rx_ferr),
      .rx_ovr       (rx_ovr),
      .rx_busy      (rx_busy)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Stand-in for the baud generator: one-cycle tick every 4 pclk.
   initial begin
      brg_rx_shift = 1'b0;
      forever begin
         repeat (3) @(negedge pclk);
         brg_rx_shift = 1'b1;
         @(negedge pclk);
         brg_rx_shift = 1'b0;
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not complete, observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one frame LSB first; the line is left at the stop-bit level.
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                input logic use_par, input logic par_bit);
      rxd = 1'b0;
      repeat (bit_clks) @(negedge pclk);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         repeat (bit_clks) @(negedge pclk);
      end
      if (use_par) begin
         rxd = par_bit;
         repeat (bit_clks) @(negedge pclk);
      end
      rxd = stop_bit;
      repeat (bit_clks) @(negedge pclk);
   endtask

   task automatic waitValid(input string tag);
      int n;
      n = 0;
      while (!rx_valid && n < 4000) begin
         @(negedge pclk);
         n++;
      end
      checkOutput(tag, {31'd0, rx_valid}, 32'd1);
   endtask

   task automatic popOne();
      rx_ready = 1'b1;
      @(negedge pclk);
      rx_ready = 1'b0;
   endtask

   initial begin
      tests    = 0;
      failed   = 0;
      bit_clks = 64;
      prst_n   = 1'b0;
      apb_en   = 1'b1;
      apb_bsel = 1'b0;
      rxd      = 1'b1;
      rx_ready = 1'b0;
      ovr_clr  = 1'b0;
`ifdef UART_RX_PARITY_EN
      apb_pen  = 1'b0;
      apb_eps  = 1'b1;
`endif
      repeat (4) @(negedge pclk);
      checkOutput("reset_data",  {24'd0, rx_data}, 32'h00);
      checkOutput("reset_valid", {31'd0, rx_valid}, 32'd0);
      checkOutput("reset_ferr",  {31'd0, rx_ferr}, 32'd0);
      checkOutput("reset_ovr",   {31'd0, rx_ovr}, 32'd0);
      checkOutput("reset_busy",  {31'd0, rx_busy}, 32'd0);
      prst_n = 1'b1;
      repeat (16) @(negedge pclk);

      // 16x oversampling, 64 pclk per bit
      fork
         applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
         begin
            repeat (3 * bit_clks) @(negedge pclk);
            checkOutput("a5_busy_mid", {31'd0, rx_busy}, 32'd1);
         end
      join
      checkOutput("a5_data",  {24'd0, rx_data}, 32'hA5);
      checkOutput("a5_valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("a5_ferr",  {31'd0, rx_ferr}, 32'd0);
      checkOutput("a5_busy",  {31'd0, rx_busy}, 32'd0);
      popOne();
      checkOutput("a5_pop_valid", {31'd0, rx_valid}, 32'd0);

      // 8x oversampling, 32 pclk per bit, back-to-back frames
      apb_bsel = 1'b1;
      bit_clks = 32;
      repeat (16) @(negedge pclk);
      fork
         begin
            applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
            applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);
         end
         begin
            waitValid("b2b_first_valid");
            checkOutput("b2b_first_data", {24'd0, rx_data}, 32'h3C);
            popOne();
            waitValid("b2b_second_valid");
            checkOutput("b2b_second_data", {24'd0, rx_data}, 32'hC3);
            popOne();
         end
      join
      checkOutput("b2b_ovr",   {31'd0, rx_ovr}, 32'd0);
      checkOutput("b2b_valid", {31'd0, rx_valid}, 32'd0);

      // Two-tick low glitch is rejected at the start-bit midpoint
      rxd = 1'b0;
      repeat (8) @(negedge pclk);
      checkOutput("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
      rxd = 1'b1;
      repeat (64) @(negedge pclk);
      checkOutput("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
      checkOutput("glitch_valid",    {31'd0, rx_valid}, 32'd0);

      // Missing stop bit followed by a held-low line gives exactly one frame
      applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
      checkOutput("brk_valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("brk_data",  {24'd0, rx_data}, 32'h55);
      checkOutput("brk_ferr",  {31'd0, rx_ferr}, 32'd1);
      popOne();
      repeat (5 * bit_clks) @(negedge pclk);
      checkOutput("brk_no_frame", {31'd0, rx_valid}, 32'd0);
      checkOutput("brk_busy",     {31'd0, rx_busy}, 32'd1);
      rxd = 1'b1;
      repeat (2 * bit_clks) @(negedge pclk);
      checkOutput("brk_idle",      {31'd0, rx_busy}, 32'd0);
      checkOutput("brk_no_frame2", {31'd0, rx_valid}, 32'd0);

      // Overrun: second frame discarded while the first is still held
      applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
      checkOutput("ovr_valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("ovr_data",  {24'd0, rx_data}, 32'h11);
      checkOutput("ovr_ferr",  {31'd0, rx_ferr}, 32'd0);
      checkOutput("ovr_flag",  {31'd0, rx_ovr}, 32'd1);
      ovr_clr = 1'b1;
      @(negedge pclk);
      ovr_clr = 1'b0;
      checkOutput("ovr_cleared", {31'd0, rx_ovr}, 32'd0);
      checkOutput("ovr_kept",    {31'd0, rx_valid}, 32'd1);

      // Reset in the middle of data bit 4, with a frame still held
      fork
         applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
         begin
            repeat (5 * bit_clks + bit_clks / 2) @(negedge pclk);
            checkOutput("rst_busy_before", {31'd0, rx_busy}, 32'd1);
            prst_n = 1'b0;
            @(negedge pclk);
            prst_n = 1'b1;
            checkOutput("rst_data",  {24'd0, rx_data}, 32'h00);
            checkOutput("rst_valid", {31'd0, rx_valid}, 32'd0);
            checkOutput("rst_busy",  {31'd0, rx_busy}, 32'd0);
            checkOutput("rst_ferr",  {31'd0, rx_ferr}, 32'd0);
            checkOutput("rst_ovr",   {31'd0, rx_ovr}, 32'd0);
         end
      join
      checkOutput("rst_stays_idle", {31'd0, rx_valid}, 32'd0);
      repeat (bit_clks) @(negedge pclk);
      applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
      checkOutput("post_rst_valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("post_rst_data",  {24'd0, rx_data}, 32'h81);
      checkOutput("post_rst_ferr",  {31'd0, rx_ferr}, 32'd0);
      popOne();

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones, so the correct parity bit is 1
      apb_pen = 1'b1;
      apb_eps = 1'b1;
      repeat (16) @(negedge pclk);
      applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
      checkOutput("par_bad_valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("par_bad_data",  {24'd0, rx_data}, 32'h07);
      checkOutput("par_bad_perr",  {31'd0, rx_perr}, 32'd1);
      checkOutput("par_bad_ferr",  {31'd0, rx_ferr}, 32'd0);
      popOne();
      applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
      checkOutput("par_good_data", {24'd0, rx_data}, 32'h07);
      checkOutput("par_good_perr", {31'd0, rx_perr}, 32'd0);
      popOne();
`endif

      repeat (8) @(negedge pclk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
